// File: rtl/hazard_tracker_pkg.sv
// Shared constants for the hazard tracker and the D-stage decoder:
// forwarding-mux select codes, Tnew classes and the "operand unused" Tuse.
package hazard_tracker_pkg;

    // Forwarding select codes driven onto the bypass muxes
    localparam logic [1:0] FWD_RF = 2'd0;  // register file / pipeline value
    localparam logic [1:0] FWD_E  = 2'd1;  // E-stage result (PC+8)
    localparam logic [1:0] FWD_M  = 2'd2;  // M-stage result
    localparam logic [1:0] FWD_W  = 2'd3;  // W-stage write-back data

    // Tnew classes, counted from entry into E
    localparam logic [2:0] PC_T  = 3'd0;
    localparam logic [2:0] ALU_T = 3'd1;
    localparam logic [2:0] DM_T  = 3'd2;

    // Tuse of an operand the instruction never reads
    localparam logic [2:0] TUSE_NONE = 3'd7;

    // Earliest stage at which an operand is needed; the lowest flag wins
    function automatic logic [2:0] eff_tuse(input logic t0, input logic t1, input logic t2);
        if (t0)
            return 3'd0;
        else if (t1)
            return 3'd1;
        else if (t2)
            return 3'd2;
        else
            return TUSE_NONE;
    endfunction

endpackage

// File: rtl/hazard_tracker_fwd_sel.sv
// Priority bypass comparator: picks the youngest in-flight producer of a
// source register whose result is already available (E > M > W).
// Unused stage inputs are tied to register 0, which can never match.
module hazard_fwd_sel
    import hazard_tracker_pkg::*;
#(
    parameter int unsigned RAW = 5,
    parameter int unsigned TW  = 3
) (
    input  logic [RAW-1:0] src_i,
    input  logic [RAW-1:0] e_a3_i,
    input  logic [TW-1:0]  e_tnew_i,
    input  logic [RAW-1:0] m_a3_i,
    input  logic [TW-1:0]  m_tnew_i,
    input  logic [RAW-1:0] w_a3_i,
    output logic [1:0]     sel_o
);

    // Youngest ready producer wins; register 0 never forwards
    always_comb begin
        sel_o = FWD_RF;
        if (src_i != '0) begin
            if (src_i == e_a3_i && e_tnew_i == '0)
                sel_o = FWD_E;
            else if (src_i == m_a3_i && m_tnew_i == '0)
                sel_o = FWD_M;
            else if (src_i == w_a3_i)
                sel_o = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_tracker.sv
// Hazard tracker for the 5-stage pipeline: shadows destination/Tnew of the
// instructions in E/M/W, raises the load-use style stall and drives every
// bypass-mux select, and counts stalled cycles (saturating).
module hazard_tracker
    import hazard_tracker_pkg::*;
#(
    parameter int unsigned RAW  = 5,
    parameter int unsigned TW   = 3,
    parameter int unsigned CNTW = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [RAW-1:0]  d_rs,
    input  logic [RAW-1:0]  d_rt,
    input  logic            d_tuse_rs0,
    input  logic            d_tuse_rs1,
    input  logic            d_tuse_rt0,
    input  logic            d_tuse_rt1,
    input  logic            d_tuse_rt2,
    input  logic [TW-1:0]   d_tnew,
    input  logic [RAW-1:0]  d_a3,
    input  logic            d_regwrite,
    output logic            stall,
    output logic [1:0]      fwd_d_rs,
    output logic [1:0]      fwd_d_rt,
    output logic [1:0]      fwd_e_rs,
    output logic [1:0]      fwd_e_rt,
    output logic [1:0]      fwd_m_rt,
    output logic [CNTW-1:0] stall_cnt
);

    // Shadow pipeline state
    logic [RAW-1:0]  e_a3_q, e_a3_d;
    logic [TW-1:0]   e_tnew_q, e_tnew_d;
    logic [RAW-1:0]  e_rs_q, e_rs_d;
    logic [RAW-1:0]  e_rt_q, e_rt_d;
    logic [RAW-1:0]  m_a3_q, m_a3_d;
    logic [TW-1:0]   m_tnew_q, m_tnew_d;
    logic [RAW-1:0]  m_rt_q, m_rt_d;
    logic [RAW-1:0]  w_a3_q, w_a3_d;
    logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

    logic [TW-1:0]   tuse_rs;
    logic [TW-1:0]   tuse_rt;

    assign tuse_rs = TW'(eff_tuse(d_tuse_rs0, d_tuse_rs1, 1'b0));
    assign tuse_rt = TW'(eff_tuse(d_tuse_rt0, d_tuse_rt1, d_tuse_rt2));

    // Stall when a D operand is needed before its E or M producer can supply it
    always_comb begin
        stall = 1'b0;
        if (d_rs != '0) begin
            if (d_rs == e_a3_q && tuse_rs < e_tnew_q)
                stall = 1'b1;
            if (d_rs == m_a3_q && tuse_rs < m_tnew_q)
                stall = 1'b1;
        end
        if (d_rt != '0) begin
            if (d_rt == e_a3_q && tuse_rt < e_tnew_q)
                stall = 1'b1;
            if (d_rt == m_a3_q && tuse_rt < m_tnew_q)
                stall = 1'b1;
        end
    end

    // Next shadow state: E takes D (or a bubble), M/W always advance
    always_comb begin
        if (stall) begin
            e_a3_d   = '0;
            e_tnew_d = '0;
            e_rs_d   = '0;
            e_rt_d   = '0;
        end else begin
            e_a3_d   = d_regwrite ? d_a3 : '0;
            e_tnew_d = d_tnew;
            e_rs_d   = d_rs;
            e_rt_d   = d_rt;
        end
        m_a3_d   = e_a3_q;
        m_tnew_d = (e_tnew_q == '0) ? '0 : e_tnew_q - TW'(1);
        m_rt_d   = e_rt_q;
        w_a3_d   = m_a3_q;
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + CNTW'(1);
    end

    // Register shadow state and stall counter; synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!reset) begin
            e_a3_q      <= '0;
            e_tnew_q    <= '0;
            e_rs_q      <= '0;
            e_rt_q      <= '0;
            m_a3_q      <= '0;
            m_tnew_q    <= '0;
            m_rt_q      <= '0;
            w_a3_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            e_a3_q      <= e_a3_d;
            e_tnew_q    <= e_tnew_d;
            e_rs_q      <= e_rs_d;
            e_rt_q      <= e_rt_d;
            m_a3_q      <= m_a3_d;
            m_tnew_q    <= m_tnew_d;
            m_rt_q      <= m_rt_d;
            w_a3_q      <= w_a3_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

    // D-stage compare/jr operands can take E, M or W
    hazard_fwd_sel #(.RAW(RAW), .TW(TW)) u_fwd_d_rs (
        .src_i(d_rs), .e_a3_i(e_a3_q), .e_tnew_i(e_tnew_q),
        .m_a3_i(m_a3_q), .m_tnew_i(m_tnew_q), .w_a3_i(w_a3_q), .sel_o(fwd_d_rs)
    );

    hazard_fwd_sel #(.RAW(RAW), .TW(TW)) u_fwd_d_rt (
        .src_i(d_rt), .e_a3_i(e_a3_q), .e_tnew_i(e_tnew_q),
        .m_a3_i(m_a3_q), .m_tnew_i(m_tnew_q), .w_a3_i(w_a3_q), .sel_o(fwd_d_rt)
    );

    // E-stage ALU operands can take M or W only
    hazard_fwd_sel #(.RAW(RAW), .TW(TW)) u_fwd_e_rs (
        .src_i(e_rs_q), .e_a3_i('0), .e_tnew_i('0),
        .m_a3_i(m_a3_q), .m_tnew_i(m_tnew_q), .w_a3_i(w_a3_q), .sel_o(fwd_e_rs)
    );

    hazard_fwd_sel #(.RAW(RAW), .TW(TW)) u_fwd_e_rt (
        .src_i(e_rt_q), .e_a3_i('0), .e_tnew_i('0),
        .m_a3_i(m_a3_q), .m_tnew_i(m_tnew_q), .w_a3_i(w_a3_q), .sel_o(fwd_e_rt)
    );

    // M-stage store data can take W only
    hazard_fwd_sel #(.RAW(RAW), .TW(TW)) u_fwd_m_rt (
        .src_i(m_rt_q), .e_a3_i('0), .e_tnew_i('0),
        .m_a3_i('0), .m_tnew_i('0), .w_a3_i(w_a3_q), .sel_o(fwd_m_rt)
    );

endmodule

// File: tb/tb_hazard_tracker.sv
// Scoreboard bench for hazard_tracker: a driver issues D-stage instructions
// (directed program fragments, then random), predicts every output from an
// instruction-level model of the E/M/W occupants and queues the prediction;
// a monitor on the falling edge pops and compares.
module tb_hazard_tracker;

    localparam int RAW  = 5;
    localparam int TW   = 3;
    localparam int CNTW = 5;   // narrow counter so saturation is reachable

    logic            clk = 1'b0;
    logic            reset;
    logic [RAW-1:0]  d_rs, d_rt, d_a3;
    logic            d_tuse_rs0, d_tuse_rs1, d_tuse_rt0, d_tuse_rt1, d_tuse_rt2;
    logic [TW-1:0]   d_tnew;
    logic            d_regwrite;
    logic            stall;
    logic [1:0]      fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt;
    logic [CNTW-1:0] stall_cnt;

    always #5 clk = ~clk;

    hazard_tracker #(.RAW(RAW), .TW(TW), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt),
        .d_tuse_rs0(d_tuse_rs0), .d_tuse_rs1(d_tuse_rs1),
        .d_tuse_rt0(d_tuse_rt0), .d_tuse_rt1(d_tuse_rt1), .d_tuse_rt2(d_tuse_rt2),
        .d_tnew(d_tnew), .d_a3(d_a3), .d_regwrite(d_regwrite),
        .stall(stall),
        .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
        .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt), .fwd_m_rt(fwd_m_rt),
        .stall_cnt(stall_cnt)
    );

    // In-flight instruction as issued from D; slot 0 = E, 1 = M, 2 = W
    typedef struct {
        int a3;
        int tnew;
        int rs;
        int rt;
    } instr_t;

    typedef struct {
        bit stall;
        int fdrs, fdrt, fers, fert, fmrt;
        int cnt;
    } exp_t;

    instr_t pipe[3];
    int     cnt_model;
    exp_t   sb[$];
    int     checks = 0;
    int     errors = 0;

    // Cycles still needed before the instruction aged 'age' stages past E has its result
    function automatic int remaining(int age);
        int r;
        r = pipe[age].tnew - age;
        return (r < 0) ? 0 : r;
    endfunction

    function automatic int tuse_of(bit t0, bit t1, bit t2);
        if (t0) return 0;
        if (t1) return 1;
        if (t2) return 2;
        return 7;
    endfunction

    function automatic bit needs_stall(int src, int tuse);
        if (src == 0) return 1'b0;
        for (int age = 0; age < 2; age++)
            if (pipe[age].a3 == src && tuse < remaining(age)) return 1'b1;
        return 1'b0;
    endfunction

    // Youngest ready producer at or past first_age; W data is always ready
    function automatic int bypass(int src, int first_age);
        if (src == 0) return 0;
        for (int age = first_age; age < 3; age++)
            if (pipe[age].a3 == src && (age == 2 || remaining(age) == 0)) return age + 1;
        return 0;
    endfunction

    task automatic put(input int rs, input int rt, input bit rs0, input bit rs1,
                       input bit rt0, input bit rt1, input bit rt2,
                       input int tnew, input int a3, input bit rw);
        d_rs = RAW'(rs);  d_rt = RAW'(rt);
        d_tuse_rs0 = rs0; d_tuse_rs1 = rs1;
        d_tuse_rt0 = rt0; d_tuse_rt1 = rt1; d_tuse_rt2 = rt2;
        d_tnew = TW'(tnew); d_a3 = RAW'(a3); d_regwrite = rw;
    endtask

    // One clock: predict outputs for the current inputs, then advance the model
    task automatic cycle(input bit chk, output bit s);
        exp_t e;
        s = needs_stall(int'(d_rs), tuse_of(d_tuse_rs0, d_tuse_rs1, 1'b0)) ||
            needs_stall(int'(d_rt), tuse_of(d_tuse_rt0, d_tuse_rt1, d_tuse_rt2));
        e.stall = s;
        e.fdrs  = bypass(int'(d_rs), 0);
        e.fdrt  = bypass(int'(d_rt), 0);
        e.fers  = bypass(pipe[0].rs, 1);
        e.fert  = bypass(pipe[0].rt, 1);
        e.fmrt  = bypass(pipe[1].rt, 2);
        e.cnt   = cnt_model;
        if (chk) sb.push_back(e);
        @(posedge clk);
        if (!reset) begin
            for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0};
            cnt_model = 0;
        end else begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (s) pipe[0] = '{0, 0, 0, 0};
            else   pipe[0] = '{(d_regwrite ? int'(d_a3) : 0), int'(d_tnew), int'(d_rs), int'(d_rt)};
            if (s && cnt_model < (1 << CNTW) - 1) cnt_model++;
        end
        #1;
    endtask

    // Hold the D instruction while stalled, as the real F/D register does
    task automatic issue();
        bit s;
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, s);
            if (!s) break;
        end
    endtask

    task automatic nops(input int n);
        put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < n; k++) issue();
    endtask

    task automatic cmp(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    // Monitor: compare DUT outputs against the oldest prediction
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            cmp("stall",     int'(stall),     int'(e.stall));
            cmp("fwd_d_rs",  int'(fwd_d_rs),  e.fdrs);
            cmp("fwd_d_rt",  int'(fwd_d_rt),  e.fdrt);
            cmp("fwd_e_rs",  int'(fwd_e_rs),  e.fers);
            cmp("fwd_e_rt",  int'(fwd_e_rt),  e.fert);
            cmp("fwd_m_rt",  int'(fwd_m_rt),  e.fmrt);
            cmp("stall_cnt", int'(stall_cnt), e.cnt);
        end
    end

    function automatic int rand_reg();
        case ($urandom_range(0, 4))
            0: return 0;
            1: return 1;
            2: return 2;
            3: return 3;
            default: return 31;
        endcase
    endfunction

    initial begin
        bit s;
        for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0};
        cnt_model = 0;

        // Reset, then a checked reset cycle with non-matching D operands
        reset = 1'b0;
        put(4, 5, 1, 0, 1, 0, 0, 1, 6, 1);
        cycle(1'b0, s);
        cycle(1'b1, s);
        reset = 1'b1;

        // lw $8,0($4) ; addu $9,$8,$10
        put(4, 8, 0, 1, 0, 0, 0, 2, 8, 1);  issue();
        put(8, 10, 0, 1, 0, 1, 0, 1, 9, 1); issue();
        nops(3);

        // addu $8,$1,$2 ; beq $8,$0
        put(1, 2, 0, 1, 0, 1, 0, 1, 8, 1);  issue();
        put(8, 0, 1, 0, 1, 0, 0, 0, 0, 0);  issue();
        nops(3);

        // jal ; jr $31
        put(0, 0, 0, 0, 0, 0, 0, 0, 31, 1); issue();
        put(31, 0, 1, 0, 0, 0, 0, 0, 0, 0); issue();
        nops(3);

        // ori $5,$0 ; sw $5,0($6)
        put(0, 5, 0, 1, 0, 0, 0, 1, 5, 1);  issue();
        put(6, 5, 0, 1, 0, 0, 1, 0, 0, 0);  issue();
        nops(3);

        // addu $0,$1,$2 ; addu $3,$0,$0
        put(1, 2, 0, 1, 0, 1, 0, 1, 0, 1);  issue();
        put(0, 0, 0, 1, 0, 1, 0, 1, 3, 1);  issue();
        nops(3);

        // Reset held low for two cycles while a load-use stall is pending
        put(4, 8, 0, 1, 0, 0, 0, 2, 8, 1);  issue();
        put(8, 10, 1, 0, 0, 1, 0, 1, 9, 1);
        cycle(1'b1, s);
        reset = 1'b0;
        cycle(1'b1, s);
        cycle(1'b1, s);
        reset = 1'b1;
        issue();
        nops(3);

        // Random instruction stream, D held while stalled
        s = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            if (!s)
                put(rand_reg(), rand_reg(),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 2)), rand_reg(),
                    1'($urandom_range(0, 1)));
            reset = ($urandom_range(0, 399) != 0);
            cycle(1'b1, s);
            if (!reset) s = 1'b0;
        end
        reset = 1'b1;

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
